// File: rtl/kill_the_bit_game_pkg.sv
// Shared types and constants for the Kill the Bit game engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   LED_W          width of the LED pattern / button bus
//   WAIT_W         width of the driver's post-transaction wait counter
//   game_state_t   game engine FSM states
//   rotate1        rotate a pattern by one LED position
package kill_the_bit_pkg;

    localparam int LED_W  = 8;
    localparam int WAIT_W = 28;

    typedef enum logic [3:0] {
        S_INIT,
        S_TICK,
        S_BTN_REQ,
        S_BTN_ACK,
        S_BTN_WAIT,
        S_UPDATE,
        S_LED_REQ,
        S_LED_ACK,
        S_LED_WAIT
    } game_state_t;

    // left=1: bit i moves to bit i+1, with bit 7 wrapping to bit 0.
    function automatic logic [LED_W-1:0] rotate1(input logic [LED_W-1:0] v,
                                                 input logic             left);
        return left ? {v[LED_W-2:0], v[LED_W-1]} : {v[0], v[LED_W-1:1]};
    endfunction

endpackage

// File: rtl/kill_the_bit_game_step_timer.sv
// Step timer: counts enabled cycles and flags the last one of each step period.
// Latency: o_tick is combinational, high in the STEP_CYCLES-th enabled cycle.
// Backpressure: i_en low freezes the count; i_clr returns it to zero.
//
// Ports:
//   i_clk, i_rst   clock, async active-high reset
//   i_en           count this cycle
//   i_clr          force the count back to zero (wins over i_en)
//   o_tick         high while enabled and the count sits on STEP_CYCLES-1
module ktb_step_timer #(
    parameter int STEP_CYCLES = 1800000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign o_tick = i_en && (cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_clr || o_tick) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/kill_the_bit_game.sv
// Kill the Bit game engine driving the request side of a TM1638 LED&KEY driver.
// Latency: one LED write per step; step = STEP_CYCLES run cycles + driver transaction time.
// Backpressure: requests wait for i_idle; i_run low freezes the step timer only.
//
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_run                         advance the game
//   i_idle, i_btn_state           driver status and debounced button state (1 = pressed)
//   o_btn_en, o_all_led_en        one-cycle driver requests
//   o_data, o_wait_counter        LED pattern for the write request, driver wait (always 0)
//   o_pattern, o_win, o_wins      game state, win pulse, saturating win count
module kill_the_bit_game
    import kill_the_bit_pkg::*;
#(
    parameter int              CLOCK_FREQ_MHz = 12,
    parameter int              STEP_CYCLES    = CLOCK_FREQ_MHz * 150000,
    parameter logic [LED_W-1:0] INIT_PATTERN  = 8'b0000_0001,
    parameter int              ROTATE_LEFT    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_idle,
    input  logic [LED_W-1:0]  i_btn_state,
    output logic              o_btn_en,
    output logic              o_all_led_en,
    output logic [LED_W-1:0]  o_data,
    output logic [WAIT_W-1:0] o_wait_counter,
    output logic [LED_W-1:0]  o_pattern,
    output logic              o_win,
    output logic [LED_W-1:0]  o_wins
);

    game_state_t      state;
    logic [LED_W-1:0] btn_prev;
    logic [LED_W-1:0] btn_new;
    logic [LED_W-1:0] toggled;
    logic             step_en;
    logic             step_clr;
    logic             step_tick;

    assign o_wait_counter = '0;

    // Only rising button edges toggle bits; a button held across reads counts once.
    assign btn_new = i_btn_state & ~btn_prev;
    assign toggled = o_pattern ^ btn_new;

    assign step_en  = (state == S_TICK) && i_run;
    assign step_clr = (state != S_TICK);

    ktb_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (step_en),
        .i_clr  (step_clr),
        .o_tick (step_tick)
    );

    // The ACK states span two cycles: the cycle the enable is visible and the
    // cycle after it, during which the driver may still report idle.  The
    // enable register itself tells the two apart.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_INIT;
            o_btn_en     <= 1'b0;
            o_all_led_en <= 1'b0;
            o_data       <= '0;
            o_pattern    <= INIT_PATTERN;
            o_win        <= 1'b0;
            o_wins       <= '0;
            btn_prev     <= '1;
        end else begin
            o_btn_en     <= 1'b0;
            o_all_led_en <= 1'b0;
            o_win        <= 1'b0;
            case (state)
                S_INIT, S_LED_REQ: begin
                    if (i_idle) begin
                        o_all_led_en <= 1'b1;
                        o_data       <= o_pattern;
                        state        <= S_LED_ACK;
                    end
                end
                S_TICK: begin
                    if (step_tick) begin
                        state <= S_BTN_REQ;
                    end
                end
                S_BTN_REQ: begin
                    if (i_idle) begin
                        o_btn_en <= 1'b1;
                        state    <= S_BTN_ACK;
                    end
                end
                S_BTN_ACK: begin
                    if (!o_btn_en) begin
                        state <= S_BTN_WAIT;
                    end
                end
                S_BTN_WAIT: begin
                    if (i_idle) begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    btn_prev <= i_btn_state;
                    // Win is judged before rotation so a full kill is never hidden.
                    if (toggled == '0) begin
                        o_pattern <= INIT_PATTERN;
                        o_win     <= 1'b1;
                        if (o_wins != '1) begin
                            o_wins <= o_wins + 8'd1;
                        end
                    end else begin
                        o_pattern <= rotate1(toggled, ROTATE_LEFT != 0);
                    end
                    state <= S_LED_REQ;
                end
                S_LED_ACK: begin
                    if (!o_all_led_en) begin
                        state <= S_LED_WAIT;
                    end
                end
                S_LED_WAIT: begin
                    if (i_idle) begin
                        state <= S_TICK;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kill_the_bit_game.sv
// Bench for kill_the_bit_game: driver model, transaction-level game model, scripted and random play.
module tb_kill_the_bit_game;

    logic        i_clk;
    logic        i_rst;
    logic        i_run;
    logic        i_idle;
    logic [7:0]  i_btn_state;
    logic        o_btn_en;
    logic        o_all_led_en;
    logic [7:0]  o_data;
    logic [27:0] o_wait_counter;
    logic [7:0]  o_pattern;
    logic        o_win;
    logic [7:0]  o_wins;

    kill_the_bit_game #(
        .CLOCK_FREQ_MHz (12),
        .STEP_CYCLES    (4),
        .INIT_PATTERN   (8'h01),
        .ROTATE_LEFT    (1)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_run          (i_run),
        .i_idle         (i_idle),
        .i_btn_state    (i_btn_state),
        .o_btn_en       (o_btn_en),
        .o_all_led_en   (o_all_led_en),
        .o_data         (o_data),
        .o_wait_counter (o_wait_counter),
        .o_pattern      (o_pattern),
        .o_win          (o_win),
        .o_wins         (o_wins)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // game model
    logic [7:0] m_pat, m_prev, m_wins;
    int         m_win_events;
    bit         expect_led;

    // observations
    logic [7:0] led_log[$];
    int         btn_count = 0;
    int         en_count = 0;
    int         dut_win_pulses = 0;

    // driver model / stimulus control
    int         drv_busy = 0;
    int         lat_fixed = 2;
    bit         force_busy = 0;
    bit         rand_mode = 0;
    logic [7:0] script[$];

    logic [7:0] exp_walk [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                  8'h40, 8'h80, 8'h01, 8'h42, 8'h84};
    logic [7:0] exp_win  [4]  = '{8'h01, 8'h02, 8'h04, 8'h01};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rotate left by one LED, wrapping: plain arithmetic on the byte value.
    function automatic logic [7:0] rot_left(input logic [7:0] v);
        int x;
        x = int'(v);
        return 8'(((x * 2) % 256) + (x / 128));
    endfunction

    task automatic model_reset();
        m_pat          = 8'h01;
        m_prev         = 8'hFF;
        m_wins         = 8'd0;
        m_win_events   = 0;
        dut_win_pulses = 0;
        expect_led     = 1'b1;
        led_log.delete();
    endtask

    task automatic model_step(input logic [7:0] b);
        logic [7:0] pressed;
        logic [7:0] t;
        pressed = b & ~m_prev;
        m_prev  = b;
        t       = m_pat ^ pressed;
        if (t == 8'h00) begin
            m_pat = 8'h01;
            m_win_events++;
            if (m_wins != 8'd255) m_wins = m_wins + 8'd1;
        end else begin
            m_pat = rot_left(t);
        end
    endtask

    // Monitor + driver model, evaluated on the falling edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                check("wait_counter", 32'(o_wait_counter), 0);
                if (o_win) dut_win_pulses++;
                if (o_btn_en || o_all_led_en) begin
                    en_count++;
                    check("one_enable", 32'(o_btn_en && o_all_led_en), 0);
                    check("enable_while_idle", 32'(i_idle), 1);
                    check("request_order", 32'(o_all_led_en), 32'(expect_led));
                    drv_busy = rand_mode ? $urandom_range(1, 6) : lat_fixed;
                end else if (drv_busy > 0) begin
                    drv_busy--;
                end
                i_idle = (drv_busy == 0) && !force_busy;
                if (o_btn_en) begin
                    logic [7:0] b;
                    btn_count++;
                    if (script.size() > 0) begin
                        b = script.pop_front();
                    end else if (rand_mode) begin
                        case ($urandom % 4)
                            0:       b = 8'h00;
                            1:       b = 8'($urandom);
                            2:       b = m_pat;
                            default: b = m_prev;
                        endcase
                    end else begin
                        b = 8'h00;
                    end
                    i_btn_state = b;
                    model_step(b);
                    expect_led = 1'b1;
                end
                if (o_all_led_en) begin
                    led_log.push_back(o_data);
                    check("led_data", 32'(o_data), 32'(m_pat));
                    check("pattern", 32'(o_pattern), 32'(m_pat));
                    check("wins", 32'(o_wins), 32'(m_wins));
                    check("win_pulses", dut_win_pulses, m_win_events);
                    expect_led = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int c;
        c = 0;
        while (led_log.size() < n && c < budget) begin
            tick();
            c++;
        end
        check("write_timeout", 32'(led_log.size() >= n), 1);
    endtask

    task automatic do_reset();
        i_rst       = 1'b1;
        drv_busy    = 0;
        i_idle      = 1'b1;
        i_btn_state = 8'h00;
        script.delete();
        model_reset();
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        int n;
        int e0;
        int c;
        logic [7:0] p;
        i_rst = 1'b1; i_run = 1'b1; i_idle = 1'b1; i_btn_state = 8'h00;
        model_reset();
        tick();
        tick();
        check("rst_pattern", 32'(o_pattern), 32'h01);
        check("rst_wins", 32'(o_wins), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_enables", 32'({o_btn_en, o_all_led_en}), 0);
        check("rst_win", 32'(o_win), 0);
        i_rst = 1'b0;

        // Walk with no buttons, then button 5 pressed and held.
        for (int k = 0; k < 8; k++) script.push_back(8'h00);
        script.push_back(8'h20);
        script.push_back(8'h20);
        wait_writes(11, 1000);
        for (int k = 0; k < 11 && k < led_log.size(); k++)
            check($sformatf("walk_write_%0d", k), 32'(led_log[k]), 32'(exp_walk[k]));
        check("walk_model_end", 32'(m_pat), 32'h84);

        // Slow driver: 50 busy cycles after every enable.
        lat_fixed = 50;
        n = led_log.size();
        wait_writes(n + 3, 2000);

        // Reset while waiting on a busy driver after a button read.
        e0 = btn_count;
        c  = 0;
        while (btn_count == e0 && c < 500) begin tick(); c++; end
        check("btn_read_seen", 32'(btn_count != e0), 1);
        repeat (4) tick();
        force_busy = 1'b1;
        i_idle     = 1'b0;
        drv_busy   = 0;
        check("pre_rst_data_nonzero", 32'(o_data != 8'h00), 1);
        i_rst = 1'b1;
        #1;
        check("arst_btn_en", 32'(o_btn_en), 0);
        check("arst_led_en", 32'(o_all_led_en), 0);
        check("arst_data", 32'(o_data), 0);
        check("arst_pattern", 32'(o_pattern), 32'h01);
        check("arst_wins", 32'(o_wins), 0);
        model_reset();
        script.delete();
        tick();
        tick();
        i_rst = 1'b0;
        e0 = en_count;
        repeat (20) tick();
        check("no_req_while_busy", en_count, e0);
        lat_fixed  = 2;
        force_busy = 1'b0;
        i_idle     = 1'b1;

        // Kill the single lit bit at 8'h04.
        script.push_back(8'h00);
        script.push_back(8'h00);
        script.push_back(8'h04);
        wait_writes(4, 500);
        for (int k = 0; k < 4 && k < led_log.size(); k++)
            check($sformatf("win_write_%0d", k), 32'(led_log[k]), 32'(exp_win[k]));
        check("win_count", 32'(o_wins), 1);
        check("win_pulse_count", dut_win_pulses, 1);

        // Freeze the game.
        n = led_log.size();
        wait_writes(n + 1, 500);
        i_run = 1'b0;
        p  = o_pattern;
        e0 = en_count;
        repeat (120) tick();
        check("frozen_no_requests", en_count, e0);
        check("frozen_pattern", 32'(o_pattern), 32'(p));
        i_run = 1'b1;

        // Random play with random driver latency and run gaps.
        rand_mode = 1'b1;
        n = led_log.size();
        c = 0;
        while (led_log.size() < n + 300 && c < 20000) begin
            i_run = ($urandom % 8) != 0;
            tick();
            c++;
        end
        check("random_progress", 32'(led_log.size() >= n + 300), 1);
        i_run     = 1'b1;
        rand_mode = 1'b0;
        repeat (10) tick();

        // Win 260 times: the counter must stick at 255.
        do_reset();
        for (int k = 0; k < 260; k++) begin
            script.push_back(8'h00);
            script.push_back(8'h02);
        end
        wait_writes(521, 15000);
        check("sat_wins", 32'(o_wins), 255);
        check("sat_model_wins", 32'(m_wins), 255);
        check("sat_win_pulses", dut_win_pulses, 260);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
